// File: rtl/sprite_cmd_unit_if.sv
// Sprite engine request bus: one req/ack transaction per sprite instruction.
// Latency: n/a (wires only); read data is valid in the same cycle as spr_ack.
// Backpressure: spr_req is held with stable fields until spr_ack or the unit gives up.
// Ports (master = command unit, slave = sprite engine):
//   spr_req, spr_addr[7:0], spr_action[3:0], spr_we, spr_wdata[31:0]  master -> slave
//   spr_ack, spr_rdata[31:0]                                          slave  -> master
interface sprite_cmd_unit_if;
    logic        spr_req;
    logic [7:0]  spr_addr;
    logic [3:0]  spr_action;
    logic        spr_we;
    logic [31:0] spr_wdata;
    logic        spr_ack;
    logic [31:0] spr_rdata;

    modport master (
        output spr_req, spr_addr, spr_action, spr_we, spr_wdata,
        input  spr_ack, spr_rdata
    );

    modport slave (
        input  spr_req, spr_addr, spr_action, spr_we, spr_wdata,
        output spr_ack, spr_rdata
    );
endinterface

// File: rtl/sprite_cmd_unit.sv
// EX-stage sprite command unit: turns one sprite instruction into one engine req/ack transaction.
// Latency: stall asserts in the issue cycle; result/valid one cycle after spr_ack (or timeout).
// Backpressure: sprite_stall holds ID/EX while the transaction is open; DONE persists under hlt.
// Ports: clk, rst (sync, active-high), flush, hlt, EX_* sprite fields from ID/EX,
//        spr (engine bus, master side), sprite_stall, spr_result/_valid, spr_wb_en,
//        spr_dst_reg, spr_err.
module sprite_cmd_unit #(
    parameter int TIMEOUT = 256,
    parameter int CNT_W   = 9
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              flush,
    input  logic              hlt,
    input  logic [7:0]        EX_sprite_addr,
    input  logic [3:0]        EX_sprite_action,
    input  logic              EX_sprite_use_imm,
    input  logic              EX_sprite_re,
    input  logic              EX_sprite_we,
    input  logic              EX_sprite_use_dst_reg,
    input  logic [13:0]       EX_sprite_imm,
    input  logic [31:0]       EX_t_data,
    input  logic [4:0]        EX_dst_reg,
    sprite_cmd_unit_if.master spr,
    output logic              sprite_stall,
    output logic [31:0]       spr_result,
    output logic              spr_result_valid,
    output logic              spr_wb_en,
    output logic [4:0]        spr_dst_reg,
    output logic              spr_err
);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_REQ  = 2'd1,
        S_DONE = 2'd2
    } state_t;

    state_t      r_state;
    state_t      w_next;
    logic [CNT_W-1:0] r_cnt;
    logic [7:0]  r_addr;
    logic [3:0]  r_action;
    logic        r_we;
    logic [31:0] r_wdata;
    logic        r_wb;
    logic [4:0]  r_dst;
    logic [31:0] r_result;
    logic        r_err;
    logic        r_flushed;
    logic        r_first;

    logic w_start;
    logic w_timeout;

    assign w_start   = (r_state == S_IDLE) && (EX_sprite_re || EX_sprite_we) && !flush && !hlt;
    // An ack in the last allowed cycle beats the timeout.
    assign w_timeout = (r_state == S_REQ) && !spr.spr_ack && (r_cnt == CNT_W'(TIMEOUT - 1));

    always_comb begin
        w_next = r_state;
        case (r_state)
            S_IDLE:  if (w_start) w_next = S_REQ;
            S_REQ:   if (spr.spr_ack || w_timeout) w_next = S_DONE;
            // Holding DONE under hlt keeps the still-present instruction from reissuing.
            S_DONE:  if (!hlt) w_next = S_IDLE;
            default: w_next = S_IDLE;
        endcase
    end

    always_comb begin
        // Request and stall drop in the reset cycle itself, not one cycle later.
        spr.spr_req      = (r_state == S_REQ) && !rst;
        sprite_stall     = (w_start || (r_state == S_REQ)) && !rst;
        spr_result_valid = (r_state == S_DONE) && r_first;
        spr_wb_en        = (r_state == S_DONE) && r_first && r_wb && !r_err && !r_flushed;
    end

    assign spr.spr_addr   = r_addr;
    assign spr.spr_action = r_action;
    assign spr.spr_we     = r_we;
    assign spr.spr_wdata  = r_wdata;
    assign spr_result     = r_result;
    assign spr_dst_reg    = r_dst;
    assign spr_err        = r_err;

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state   <= S_IDLE;
            r_cnt     <= '0;
            r_addr    <= '0;
            r_action  <= '0;
            r_we      <= 1'b0;
            r_wdata   <= '0;
            r_wb      <= 1'b0;
            r_dst     <= '0;
            r_result  <= '0;
            r_err     <= 1'b0;
            r_flushed <= 1'b0;
            r_first   <= 1'b0;
        end else begin
            r_state <= w_next;
            case (r_state)
                S_IDLE: begin
                    if (w_start) begin
                        r_addr    <= EX_sprite_addr;
                        r_action  <= EX_sprite_action;
                        r_we      <= EX_sprite_we;   // write wins when re and we are both set
                        r_wdata   <= EX_sprite_use_imm ? {18'b0, EX_sprite_imm} : EX_t_data;
                        r_wb      <= EX_sprite_re && !EX_sprite_we && EX_sprite_use_dst_reg;
                        r_dst     <= EX_dst_reg;
                        r_err     <= 1'b0;
                        r_cnt     <= '0;
                        r_flushed <= 1'b0;
                    end
                end
                S_REQ: begin
                    r_cnt <= r_cnt + CNT_W'(1);
                    // A flushed instruction still finishes its engine transaction,
                    // it just must not write back.
                    if (flush) r_flushed <= 1'b1;
                    if (spr.spr_ack) begin
                        r_result <= r_we ? 32'd0 : spr.spr_rdata;
                        r_first  <= 1'b1;
                    end else if (w_timeout) begin
                        r_result <= 32'd0;
                        r_err    <= 1'b1;
                        r_first  <= 1'b1;
                    end
                end
                S_DONE: begin
                    r_first <= 1'b0;
                end
                default: begin
                    r_first <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_sprite_cmd_unit.sv
// Bench for sprite_cmd_unit: directed instructions, expected responses queued at issue,
// checked by independent engine, stall and completion monitors.
module tb_sprite_cmd_unit;
    localparam int TO = 8;

    logic clk, rst, flush, hlt;
    logic [7:0]  ex_addr;
    logic [3:0]  ex_act;
    logic        ex_use_imm, ex_re, ex_we, ex_use_dst;
    logic [13:0] ex_imm;
    logic [31:0] ex_tdata;
    logic [4:0]  ex_dst;
    logic        sprite_stall, spr_result_valid, spr_wb_en, spr_err;
    logic [31:0] spr_result;
    logic [4:0]  spr_dst_reg;

    sprite_cmd_unit_if spr_if ();

    sprite_cmd_unit #(.TIMEOUT(TO), .CNT_W(4)) dut (
        .clk(clk), .rst(rst), .flush(flush), .hlt(hlt),
        .EX_sprite_addr(ex_addr), .EX_sprite_action(ex_act), .EX_sprite_use_imm(ex_use_imm),
        .EX_sprite_re(ex_re), .EX_sprite_we(ex_we), .EX_sprite_use_dst_reg(ex_use_dst),
        .EX_sprite_imm(ex_imm), .EX_t_data(ex_tdata), .EX_dst_reg(ex_dst),
        .spr(spr_if), .sprite_stall(sprite_stall), .spr_result(spr_result),
        .spr_result_valid(spr_result_valid), .spr_wb_en(spr_wb_en),
        .spr_dst_reg(spr_dst_reg), .spr_err(spr_err)
    );

    typedef struct { logic [7:0] addr; logic [3:0] act; logic we; logic [31:0] wdata; int len; } req_t;
    typedef struct { int len; int gap; } stl_t;
    typedef struct { logic [31:0] result; logic err; logic wb; logic [4:0] dst; } done_t;

    req_t  exp_req_q[$];
    stl_t  exp_stl_q[$];
    done_t exp_done_q[$];

    int total = 0;
    int bad   = 0;
    int ack_at = 0;
    logic [31:0] ack_rdata = 32'd0;

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not reach its end");
        $fatal(1);
    end

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
        total++;
        if (act !== req) begin
            bad++;
            $display("FAIL %s: got %h want %h", name, act, req);
        end
    endtask

    // Engine model: acks on the requested REQ cycle, checks request fields every cycle.
    initial begin
        req_t e;
        bit   have;
        int   run;
        run = 0;
        have = 0;
        spr_if.spr_ack = 1'b0;
        spr_if.spr_rdata = 32'd0;
        forever begin
            @(negedge clk);
            if (spr_if.spr_req === 1'b1) begin
                if (run == 0) begin
                    total++;
                    if (exp_req_q.size() == 0) begin
                        bad++;
                        have = 0;
                        $display("FAIL req_unexpected: got request addr=%h want none", spr_if.spr_addr);
                    end else begin
                        e = exp_req_q.pop_front();
                        have = 1;
                    end
                end
                if (have) begin
                    chk("req_addr", {24'd0, spr_if.spr_addr}, {24'd0, e.addr});
                    chk("req_action", {28'd0, spr_if.spr_action}, {28'd0, e.act});
                    chk("req_we", {31'd0, spr_if.spr_we}, {31'd0, e.we});
                    chk("req_wdata", spr_if.spr_wdata, e.wdata);
                end
                run++;
                if (ack_at != 0 && run == ack_at) begin
                    spr_if.spr_ack = 1'b1;
                    spr_if.spr_rdata = ack_rdata;
                end else begin
                    spr_if.spr_ack = 1'b0;
                    spr_if.spr_rdata = 32'hBAD0BAD0;
                end
            end else begin
                if (run != 0 && have) chk("req_len", run, e.len);
                run = 0;
                have = 0;
                spr_if.spr_ack = 1'b0;
                spr_if.spr_rdata = 32'd0;
            end
        end
    end

    // Stall monitor: length of each stall run and the low gap before it.
    initial begin
        stl_t s;
        int hi, lo;
        hi = 0;
        lo = 0;
        forever begin
            @(negedge clk);
            if (sprite_stall === 1'b1) begin
                if (hi == 0) begin
                    total++;
                    if (exp_stl_q.size() == 0) begin
                        bad++;
                        s.len = -1;
                        s.gap = -1;
                        $display("FAIL stall_unexpected: got stall want none");
                    end else begin
                        s = exp_stl_q.pop_front();
                        if (s.gap >= 0) chk("stall_gap", lo, s.gap);
                    end
                end
                hi++;
                lo = 0;
            end else begin
                if (hi > 0 && s.len >= 0) chk("stall_len", hi, s.len);
                hi = 0;
                lo++;
            end
        end
    end

    // Completion monitor.
    initial begin
        done_t d;
        forever begin
            @(negedge clk);
            if (spr_wb_en === 1'b1 && spr_result_valid !== 1'b1) begin
                total++;
                bad++;
                $display("FAIL wb_without_valid: got wb_en=1 want 0");
            end
            if (spr_result_valid === 1'b1) begin
                total++;
                if (exp_done_q.size() == 0) begin
                    bad++;
                    $display("FAIL valid_unexpected: got valid result=%h want none", spr_result);
                end else begin
                    d = exp_done_q.pop_front();
                    chk("done_result", spr_result, d.result);
                    chk("done_err", {31'd0, spr_err}, {31'd0, d.err});
                    chk("done_wb_en", {31'd0, spr_wb_en}, {31'd0, d.wb});
                    chk("done_dst", {27'd0, spr_dst_reg}, {27'd0, d.dst});
                end
            end
        end
    end

    task automatic clear_ex();
        ex_addr = 8'd0; ex_act = 4'd0; ex_use_imm = 1'b0; ex_re = 1'b0; ex_we = 1'b0;
        ex_use_dst = 1'b0; ex_imm = 14'd0; ex_tdata = 32'd0; ex_dst = 5'd0;
    endtask

    task automatic idle_cycle();
        @(posedge clk); #1;
        clear_ex();
    endtask

    task automatic run_instr(
        input logic re, input logic we, input logic [7:0] addr, input logic [3:0] act,
        input logic use_imm, input logic [13:0] imm, input logic [31:0] tdata,
        input logic use_dst, input logic [4:0] dst,
        input int ackat, input logic [31:0] rd, input int flush_at, input int hlt_n,
        input logic x_we, input logic [31:0] x_wdata, input int x_len, input int x_stall,
        input int x_gap, input logic [31:0] x_result, input logic x_err, input logic x_wb);
        req_t  r;
        stl_t  s;
        done_t d;
        int    reqcnt;
        bit    done;
        r.addr = addr; r.act = act; r.we = x_we; r.wdata = x_wdata; r.len = x_len;
        s.len = x_stall; s.gap = x_gap;
        d.result = x_result; d.err = x_err; d.wb = x_wb; d.dst = dst;
        exp_req_q.push_back(r);
        exp_stl_q.push_back(s);
        exp_done_q.push_back(d);
        @(posedge clk); #1;
        ex_re = re; ex_we = we; ex_addr = addr; ex_act = act; ex_use_imm = use_imm;
        ex_imm = imm; ex_tdata = tdata; ex_use_dst = use_dst; ex_dst = dst;
        ack_at = ackat;
        ack_rdata = rd;
        reqcnt = 0;
        done = 0;
        for (int c = 0; c < 64 && !done; c++) begin
            @(negedge clk);
            if (spr_if.spr_req === 1'b1) begin
                reqcnt++;
                if (reqcnt == flush_at) begin
                    flush = 1'b1;
                    @(posedge clk); #1;
                    flush = 1'b0;
                end
            end else if (sprite_stall === 1'b0) begin
                if (hlt_n > 0) begin
                    hlt = 1'b1;
                    repeat (hlt_n) @(negedge clk);
                    hlt = 1'b0;
                end
                done = 1;
            end
        end
        total++;
        if (!done) begin
            bad++;
            $display("FAIL instr_complete: got no completion want completion within 64 cycles");
        end
    endtask

    initial begin
        req_t r;
        stl_t s;
        bit   seen;
        rst = 1'b1; flush = 1'b0; hlt = 1'b0;
        clear_ex();
        repeat (3) @(posedge clk);
        @(negedge clk);
        chk("rst_req", {31'd0, spr_if.spr_req}, 32'd0);
        chk("rst_stall", {31'd0, sprite_stall}, 32'd0);
        chk("rst_valid", {31'd0, spr_result_valid}, 32'd0);
        chk("rst_wb_en", {31'd0, spr_wb_en}, 32'd0);
        chk("rst_err", {31'd0, spr_err}, 32'd0);
        chk("rst_result", spr_result, 32'd0);
        chk("rst_addr", {24'd0, spr_if.spr_addr}, 32'd0);
        chk("rst_wdata", spr_if.spr_wdata, 32'd0);
        chk("rst_dst", {27'd0, spr_dst_reg}, 32'd0);
        @(posedge clk); #1;
        rst = 1'b0;
        idle_cycle();

        // read, ack on 3rd REQ cycle
        run_instr(1, 0, 8'h12, 4'h3, 0, 14'h0, 32'h11112222, 1, 5'd7, 3, 32'hCAFE0001, 0, 0,
                  0, 32'h11112222, 3, 4, -1, 32'hCAFE0001, 0, 1);
        idle_cycle();
        // write immediate, ack on first REQ cycle; rdata must be ignored
        run_instr(0, 1, 8'h34, 4'h5, 1, 14'h3FFF, 32'h55555555, 1, 5'd2, 1, 32'hDEADBEEF, 0, 0,
                  1, 32'h00003FFF, 1, 2, -1, 32'h0, 0, 0);
        idle_cycle();
        // re and we both set: treated as a write, no writeback
        run_instr(1, 1, 8'h56, 4'h9, 0, 14'h0, 32'hA5A5A5A5, 1, 5'd9, 2, 32'h12345678, 0, 0,
                  1, 32'hA5A5A5A5, 2, 3, -1, 32'h0, 0, 0);
        idle_cycle();
        // no ack: times out after TO request cycles
        run_instr(1, 0, 8'h78, 4'h1, 0, 14'h0, 32'h0, 1, 5'd4, 0, 32'h0, 0, 0,
                  0, 32'h0, TO, TO + 1, -1, 32'h0, 1, 0);
        idle_cycle();
        @(negedge clk);
        chk("err_sticky", {31'd0, spr_err}, 32'd1);
        // ack in the final allowed cycle wins over the timeout
        run_instr(1, 0, 8'h9A, 4'h2, 0, 14'h0, 32'h0, 1, 5'd5, TO, 32'h0F0F0F0F, 0, 0,
                  0, 32'h0, TO, TO + 1, -1, 32'h0F0F0F0F, 0, 1);
        idle_cycle();
        // flush in REQ cycle 2: completes once, writeback suppressed
        run_instr(1, 0, 8'hBC, 4'h6, 0, 14'h0, 32'h0, 1, 5'd3, 3, 32'h77778888, 2, 0,
                  0, 32'h0, 3, 4, -1, 32'h77778888, 0, 0);
        idle_cycle();
        // hlt held 5 cycles in DONE: single valid, no reissue
        run_instr(1, 0, 8'h01, 4'h7, 0, 14'h0, 32'h0, 1, 5'd10, 2, 32'h13572468, 0, 5,
                  0, 32'h0, 2, 3, -1, 32'h13572468, 0, 1);
        idle_cycle();
        repeat (3) @(negedge clk);
        chk("hlt_no_reissue", {31'd0, spr_if.spr_req}, 32'd0);
        // back-to-back reads: exactly one stall-low cycle between them
        run_instr(1, 0, 8'h20, 4'h0, 0, 14'h0, 32'h0, 1, 5'd11, 1, 32'hAAAA0001, 0, 0,
                  0, 32'h0, 1, 2, -1, 32'hAAAA0001, 0, 1);
        run_instr(1, 0, 8'h21, 4'h0, 0, 14'h0, 32'h0, 1, 5'd12, 2, 32'hBBBB0002, 0, 0,
                  0, 32'h0, 2, 3, 1, 32'hBBBB0002, 0, 1);
        idle_cycle();

        // flush while IDLE with a command present: nothing starts
        @(posedge clk); #1;
        ex_re = 1'b1; ex_addr = 8'h66; ex_use_dst = 1'b1; flush = 1'b1;
        @(negedge clk);
        chk("flush_idle_stall", {31'd0, sprite_stall}, 32'd0);
        @(posedge clk); #1;
        clear_ex();
        flush = 1'b0;
        @(negedge clk);
        chk("flush_idle_req", {31'd0, spr_if.spr_req}, 32'd0);

        // reset on REQ cycle 2
        r.addr = 8'h44; r.act = 4'h8; r.we = 1'b0; r.wdata = 32'h0; r.len = 1;
        s.len = 2; s.gap = -1;
        exp_req_q.push_back(r);
        exp_stl_q.push_back(s);
        @(posedge clk); #1;
        ex_re = 1'b1; ex_addr = 8'h44; ex_act = 4'h8; ex_use_dst = 1'b1; ex_dst = 5'd6;
        ack_at = 0;
        seen = 0;
        for (int c = 0; c < 10 && !seen; c++) begin
            @(negedge clk);
            if (spr_if.spr_req === 1'b1) seen = 1;
        end
        chk("rst_mid_req_seen", {31'd0, seen}, 32'd1);
        @(posedge clk); #1;
        rst = 1'b1;
        clear_ex();
        @(negedge clk);
        chk("rst_mid_req_drop", {31'd0, spr_if.spr_req}, 32'd0);
        chk("rst_mid_stall_drop", {31'd0, sprite_stall}, 32'd0);
        @(posedge clk); #1;
        rst = 1'b0;
        @(negedge clk);
        chk("rst_mid_req_after", {31'd0, spr_if.spr_req}, 32'd0);
        chk("rst_mid_stall_after", {31'd0, sprite_stall}, 32'd0);
        chk("rst_mid_valid_after", {31'd0, spr_result_valid}, 32'd0);

        // a fresh write after reset starts normally from IDLE
        run_instr(0, 1, 8'hFE, 4'hF, 0, 14'h0, 32'h0BADF00D, 0, 5'd1, 2, 32'h0, 0, 0,
                  1, 32'h0BADF00D, 2, 3, -1, 32'h0, 0, 0);
        idle_cycle();
        repeat (5) @(negedge clk);
        chk("req_q_drained", exp_req_q.size(), 32'd0);
        chk("stall_q_drained", exp_stl_q.size(), 32'd0);
        chk("done_q_drained", exp_done_q.size(), 32'd0);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
